// File: rtl/match_pkg.sv
// Shared types and constants for the match-engine round-robin arbiter.
package match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int AW_DEF   = 9;
  localparam int NREQ_MAX = 8;
  localparam int SEL_W    = $clog2(NREQ_MAX);
  localparam int CNT_W    = 10;

endpackage

// File: rtl/match_arbiter_if.sv
// Requester and engine signals of the match arbiter, grouped as one bundle.
// req is a level held by a requester until its one-cycle ack pulse; results are valid with ack.
interface match_arbiter_if
  import match_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF
);
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  ack;
  logic [AW-1:0]    result_addr;
  logic             result_hit;
  logic             result_tmo;
  logic             eng_start;
  logic [SEL_W-1:0] eng_sel;
  logic             eng_done;
  logic             eng_hit;
  logic [AW-1:0]    eng_addr;
  logic             busy;

  modport master (
    input  req, eng_done, eng_hit, eng_addr,
    output ack, result_addr, result_hit, result_tmo, eng_start, eng_sel, busy
  );

  modport slave (
    output req, eng_done, eng_hit, eng_addr,
    input  ack, result_addr, result_hit, result_tmo, eng_start, eng_sel, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick
  import match_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] grant_o,
  output logic             valid_o
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                sum;

  // Rotate so bit j of rot is request (ptr + j) mod NREQ.
  assign dbl = {req_i, req_i} >> ptr_i;
  assign rot = dbl[NREQ-1:0];

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    sum     = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (!valid_o && rot[j]) begin
        valid_o = 1'b1;
        sum     = int'(ptr_i) + j;
        grant_o = SEL_W'((sum >= NREQ) ? (sum - NREQ) : sum);
      end
    end
  end

endmodule

// File: rtl/match_arbiter.sv
// Round-robin scheduler sharing one pattern-match engine among NREQ requesters,
// with a per-search timeout and registered result/acknowledge outputs.
module match_arbiter
  import match_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = 511
) (
  input  logic            clk_i,
  input  logic            rst_i,
  match_arbiter_if.master bus,
  output state_e          state_o
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(NREQ - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             hit_q, hit_d;
  logic             tmo_q, tmo_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_valid;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .grant_o (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
        end
      end
      ST_GRANT: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        // done is checked first so it wins a tie with the timeout
        if (bus.eng_done) begin
          addr_d  = bus.eng_addr;
          hit_d   = bus.eng_hit;
          tmo_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == TMO_LAST) begin
          addr_d  = '0;
          hit_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        ptr_d   = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ack_d   = (state_d == ST_RESP) ? (NREQ'(1) << sel_d) : '0;
    start_d = (state_d == ST_GRANT);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      tmo_q   <= 1'b0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.result_addr = addr_q;
  assign bus.result_hit  = hit_q;
  assign bus.result_tmo  = tmo_q;
  assign bus.eng_start   = start_q;
  assign bus.eng_sel     = sel_q;
  assign bus.busy        = busy_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_match_arbiter.sv
// Directed and randomized bench for match_arbiter against a cycle-count reference model.
module tb_match_arbiter;
  import match_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 9;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  match_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus();
  state_e state_dbg;

  match_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TMO)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  int checks   = 0;
  int errors   = 0;
  int ptr_m    = 0;
  int last_ack = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Spec rule: first set request at or above the pointer, wrapping modulo NREQ.
  function automatic int model_pick(input logic [3:0] r, input int p);
    int idx;
    for (int i = 0; i < NREQ; i++) begin
      idx = (p + i) % NREQ;
      if (((r >> idx) & 4'd1) != 4'd0) return idx;
    end
    return 0;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},   bus.ack, 0);
    chk({tag, "_start"}, bus.eng_start, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_sel"},   bus.eng_sel, 0);
    chk({tag, "_addr"},  bus.result_addr, 0);
    chk({tag, "_hit"},   bus.result_hit, 0);
    chk({tag, "_tmo"},   bus.result_tmo, 0);
  endtask

  // d = edge (counted from the GRANT edge) at which eng_done is sampled; 0 = never.
  task automatic search(input logic [3:0] rv, input int d, input logic [8:0] a, input logic h,
                        input bit drop, input bit hold, input bit spacing);
    int         w;
    int         k_ack;
    bit         done_wins;
    logic [3:0] oh;
    w         = model_pick(rv, ptr_m);
    oh        = 4'b0001 << w;
    done_wins = (d >= 2) && (d <= TMO + 1);
    k_ack     = done_wins ? d : TMO + 1;
    bus.req   = rv;
    tick;
    chk("grant_start", bus.eng_start, 1);
    chk("grant_sel",   bus.eng_sel, w);
    chk("grant_busy",  bus.busy, 1);
    chk("grant_ack",   bus.ack, 0);
    for (int k = 1; k <= k_ack; k++) begin
      bus.eng_done = (k == d);
      bus.eng_addr = (k == d) ? a : 9'($urandom);
      bus.eng_hit  = (k == d) ? h : 1'($urandom);
      if (drop && k == 2) bus.req = rv & ~oh;
      tick;
      if (k < k_ack) begin
        chk("run_ack",   bus.ack, 0);
        chk("run_start", bus.eng_start, 0);
        chk("run_busy",  bus.busy, 1);
      end
    end
    bus.eng_done = 1'b0;
    chk("ack",       bus.ack, oh);
    chk("res_addr",  bus.result_addr, done_wins ? a : 9'd0);
    chk("res_hit",   bus.result_hit, done_wins ? h : 1'b0);
    chk("res_tmo",   bus.result_tmo, done_wins ? 1'b0 : 1'b1);
    chk("resp_busy", bus.busy, 1);
    if (spacing) chk("ack_spacing", cyc - last_ack, 4);
    last_ack = cyc;
    bus.req  = hold ? rv : 4'b0000;
    ptr_m    = (w + 1) % NREQ;
    tick;
    chk("idle_ack",   bus.ack, 0);
    chk("idle_busy",  bus.busy, 0);
    chk("idle_state", state_dbg, ST_IDLE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rv;
    bus.req      = '0;
    bus.eng_done = 1'b0;
    bus.eng_hit  = 1'b0;
    bus.eng_addr = '0;
    tick;
    tick;
    chk_reset_outputs("rst");
    chk("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    tick;

    // Fairness from pointer 0: order 0,1,2,3,0 with acks 4 cycles apart.
    for (int i = 0; i < 5; i++)
      search(4'b1111, 2, 9'($urandom), 1'($urandom), 1'b0, (i < 4), (i > 0));

    search(4'b0001, 5, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0);
    search(4'b0010, 0, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);
    search(4'b1000, TMO + 1, 9'h1C3, 1'b1, 1'b0, 1'b0, 1'b0);
    search(4'b0001, 1, 9'h055, 1'b1, 1'b0, 1'b0, 1'b0);
    search(4'b0100, 4, 9'h0F0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Spurious done while idle must not produce an ack.
    bus.eng_done = 1'b1;
    tick;
    bus.eng_done = 1'b0;
    chk("spur_ack",  bus.ack, 0);
    chk("spur_busy", bus.busy, 0);
    tick;
    chk("spur_ack2", bus.ack, 0);

    // Reset three cycles after start, then the held request is granted afresh.
    bus.req = 4'b0100;
    tick;
    chk("mid_start", bus.eng_start, 1);
    tick;
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    tick;
    chk("midrst_ack2",   bus.ack, 0);
    chk("midrst_start2", bus.eng_start, 0);
    rst   = 1'b0;
    ptr_m = 0;
    search(4'b0100, 3, 9'h123, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rv = 4'($urandom_range(1, 15));
      search(rv, $urandom_range(1, TMO + 3), 9'($urandom), 1'($urandom),
             1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_arbiter.md
# match_arbiter

Round-robin scheduler that shares the single pattern-match engine among NREQ requesters. It picks one pending requester, pulses the engine start, and waits for the engine done flag or a timeout. It then returns the match address and hit status to the granted requester with a one-cycle acknowledge. It sits between the requesting search clients and the engine FSM/compare pair, and owns the engine's start input.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 9, address width of the match location
- TIMEOUT, 511, maximum cycles allowed in RUN before the search is aborted (1..1023)

- clock  in  1  system clock (100 MHz), all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- req  in  NREQ  per-requester search request, level, held until its ack
- ack  out  NREQ  one-hot, one-cycle pulse: result valid for that requester
- result_addr  out  AW  match address returned with ack, held until next ack
- result_hit  out  1  1 = engine reported a match, valid with ack
- result_tmo  out  1  1 = search aborted by timeout, valid with ack
- eng_start  out  1  start to engine, exactly one cycle per grant
- eng_sel  out  3  index of granted requester (selects pattern source)
- eng_done  in  1  engine search finished
- eng_hit  in  1  engine found a match, valid with eng_done
- eng_addr  in  AW  engine match address, valid with eng_done
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, GRANT, RUN, RESP. Reset enters IDLE.
- Reset values: ack=0, eng_start=0, busy=0, eng_sel=0, result_addr=0, result_hit=0, result_tmo=0, priority pointer=0, timeout counter=0.
- IDLE -> GRANT when any req bit is set.
  - The winner is the first set req index at or above the pointer, wrapping modulo NREQ.
  - eng_sel is registered to the winner.
- GRANT -> RUN unconditionally.
  - eng_start=1 in GRANT only.
  - eng_done is ignored in GRANT.
  - The counter clears to 0.
- RUN: the counter increments each cycle.
  - On eng_done=1, capture eng_addr and eng_hit, set result_tmo=0, go to RESP.
  - If the counter reaches TIMEOUT-1 without eng_done, set result_addr=0, result_hit=0, result_tmo=1, go to RESP.
  - If eng_done and timeout occur in the same cycle, done wins.
- RESP: ack[eng_sel]=1 for one cycle; pointer = (eng_sel+1) mod NREQ; go to IDLE.
- Requester drop:
  - A req deasserted after grant does not cancel the search; ack still pulses.
  - req changes during GRANT, RUN or RESP do not affect the current grant.
- A requester that still holds req after its ack is re-arbitrated normally. The rotated pointer prevents starvation.
- eng_done arriving in IDLE, GRANT or RESP is discarded.
- A reset mid-search returns to IDLE immediately, with no ack and no further eng_start. The engine is reset by the same signal.

## Timing
- Req seen at edge n:
  - GRANT occupies cycle n..n+1 with eng_start high.
  - RUN begins at edge n+1.
- eng_done sampled high at edge m (in RUN): RESP and ack are high in cycle m..m+1. busy is low from edge m+1.
- Minimum req-to-ack is 3 edges. Back-to-back grants are separated by one IDLE cycle, giving 4 cycles per minimal search.
- Timeout: ack is asserted TIMEOUT+1 edges after the GRANT edge.
- All outputs are registered; no combinational path from req or eng_* to any output.

## Structure
- Shared package `match_pkg`:
  - state enum (IDLE, GRANT, RUN, RESP)
  - AW default
  - NREQ maximum
  - counter width constant (10 bits)
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: grant index, any-valid flag.
- FSM, counter, and result registers are inline in match_arbiter.

## Test plan
- Single search: req=4'b0001 with engine done 5 cycles after start, eng_hit=1, eng_addr=9'h0A5 -> one eng_start pulse, eng_sel=0, ack=4'b0001 one cycle, result_addr=9'h0A5, hit=1, tmo=0.
- Fairness: req=4'b1111 held continuously, done 2 cycles after each start -> grant order 0,1,2,3,0; each ack 4 cycles apart.
- Timeout: TIMEOUT=16, eng_done never asserted -> ack 17 edges after the GRANT edge, result_tmo=1, result_hit=0, result_addr=0.
- Collision: eng_done asserted on the last timeout cycle -> result_tmo=0, eng_addr captured.
- Reset mid-RUN: assert reset 3 cycles after start -> all outputs 0 at once, no ack. After release, held req=4'b0100 is granted with eng_sel=2.
- Spurious/dropped: eng_done pulsed in IDLE -> no ack. A req dropped during RUN -> ack still pulses for that index.
